interleaver_pingpong: RTL and testbench

// - Block interleaver for the WiMAX PHY transmit chain, QPSK rate-1/2: Ncbps=192, Ncpc=2, s=1, d=16.
// - Sits between the FEC encoder (bit-serial input, 100 MHz domain) and the QPSK modulator (bit-serial output).
// - Two 192-bit banks in ping-pong: one fills while the other drains, so streaming is continuous.

---
 rtl/interleaver_pingpong_pkg.sv | 41 ++++
 rtl/interleaver_pingpong_addr_gen.sv | 66 ++++++
 rtl/interleaver_pingpong.sv | 112 +++++++++++
 tb/tb_interleaver_pingpong.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interleaver_pingpong_pkg.sv
`default_nettype none
// ============================================================================
// Module  : interleaver_pingpong_pkg
// Purpose : Shared constants, bank-state type and reference vectors for the
//           WiMAX QPSK rate-1/2 block interleaver (Ncbps=192, d=16).
// Contents: NCBPS_QPSK, INTLV_D, INTLV_ROWS, bank_state_t,
//           INTLV_GOLDEN_IN / INTLV_GOLDEN_OUT (MSB = bit k=0 / j=0).
// Revision: 1.0 - initial release
// ============================================================================
package interleaver_pingpong_pkg;

  localparam int NCBPS_QPSK = 192;
  localparam int INTLV_D    = 16;
  localparam int INTLV_ROWS = NCBPS_QPSK / INTLV_D;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Direct-formula permutation, used only to build the reference output.
  // Vectors are MSB first: bit (NCBPS-1-k) holds coded bit k.
  function automatic logic [NCBPS_QPSK-1:0] intlv_permute(input logic [NCBPS_QPSK-1:0] din);
    logic [NCBPS_QPSK-1:0] dout;
    int m;
    dout = '0;
    for (int k = 0; k < NCBPS_QPSK; k++) begin
      m = INTLV_ROWS * (k % INTLV_D) + k / INTLV_D;
      dout[8'(NCBPS_QPSK-1-m)] = din[8'(NCBPS_QPSK-1-k)];
    end
    return dout;
  endfunction

  localparam logic [NCBPS_QPSK-1:0] INTLV_GOLDEN_IN =
    192'h3C5A_96E1_0F7B_D248_A5C3_1E6F_9B07_4D82_6AF1_C39E_58B0_27D4;
  localparam logic [NCBPS_QPSK-1:0] INTLV_GOLDEN_OUT = intlv_permute(INTLV_GOLDEN_IN);

endpackage
`default_nettype wire

// File: rtl/interleaver_pingpong_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : intlv_addr_gen
// Purpose : Incremental write-address generator for the block interleaver.
//           Produces m_k = ROWS*(k mod D) + floor(k/D) without a multiplier.
// Ports   : clk_100 - clock
//           reset   - synchronous, active-high
//           adv     - advance to the next input bit (an accepted write)
//           addr    - bank address for the current bit k
//           last    - current bit is k = NCBPS-1
// Revision: 1.0 - initial release
// ============================================================================
module intlv_addr_gen
  import interleaver_pingpong_pkg::*;
#(
  parameter int NCBPS = NCBPS_QPSK,
  parameter int D     = INTLV_D,
  parameter int AW    = 8
) (
  input  logic          clk_100,
  input  logic          reset,
  input  logic          adv,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam int ROWS = NCBPS / D;
  localparam int CW   = $clog2(D);
  localparam int RW   = $clog2(ROWS);

  localparam logic [CW-1:0] c_COL_LAST = CW'(D - 1);
  localparam logic [RW-1:0] c_ROW_LAST = RW'(ROWS - 1);
  localparam logic [AW-1:0] c_STEP     = AW'(ROWS);

  // col = k mod D, row = floor(k/D); together they are the write count.
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_addr;

  assign addr = r_addr;
  assign last = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);

  always_ff @(posedge clk_100) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (adv) begin
      if (last) begin
        r_col  <= '0;
        r_row  <= '0;
        r_addr <= '0;
      end else if (r_col == c_COL_LAST) begin
        // End of a column sweep: restart at the top of the next row offset.
        r_col  <= '0;
        r_row  <= r_row + 1'b1;
        r_addr <= AW'(r_row) + AW'(1);
      end else begin
        r_col  <= r_col + 1'b1;
        r_addr <= r_addr + c_STEP;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/interleaver_pingpong.sv
`default_nettype none
// ============================================================================
// Module  : interleaver_pingpong
// Purpose : Ping-pong block interleaver (WiMAX QPSK 1/2, 192 bits, d=16).
//           One bank fills with permuted writes while the other drains
//           sequentially, giving continuous 1 bit/cycle streaming.
// Ports   : clk_100   - sole clock
//           reset     - synchronous, active-high
//           in_data   - coded bit from FEC (k=0 first)
//           in_valid  - in_data valid
//           in_ready  - interleaver can accept a bit
//           out_data  - interleaved bit to modulator
//           out_valid - out_data valid
//           out_ready - modulator accepts
//           blk_start - marks output bit j=0 of each block
// Revision: 1.0 - initial release
// ============================================================================
module interleaver_pingpong
  import interleaver_pingpong_pkg::*;
#(
  parameter int NCBPS = NCBPS_QPSK,
  parameter int D     = INTLV_D,
  parameter int AW    = 8
) (
  input  logic clk_100,
  input  logic reset,
  input  logic in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic blk_start
);

  localparam logic [AW-1:0] c_RD_LAST = AW'(NCBPS - 1);

  logic [NCBPS-1:0] r_bank [2];
  bank_state_t      r_state [2];
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [AW-1:0]    r_rd_cnt;

  logic [AW-1:0]    w_wr_addr;
  logic             w_wr_last;
  logic             w_wr_fire;
  logic             w_rd_fire;
  logic             w_rd_last;
  bank_state_t      w_wr_state;
  bank_state_t      w_rd_state;
  logic             w_rd_bit;

  assign w_wr_state = r_state[r_wr_bank];
  assign w_rd_state = r_state[r_rd_bank];

  // Both handshake sides decode from registered state only, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (w_wr_state != FULL) && (w_wr_state != DRAINING);
  assign out_valid = (w_rd_state == FULL) || (w_rd_state == DRAINING);

  assign w_wr_fire = in_valid && in_ready;
  assign w_rd_fire = out_valid && out_ready;
  assign w_rd_last = (r_rd_cnt == c_RD_LAST);

  // Bank contents are never cleared, so gate the data while nothing is valid.
  assign w_rd_bit  = r_bank[r_rd_bank][r_rd_cnt];
  assign out_data  = out_valid && w_rd_bit;
  assign blk_start = out_valid && (r_rd_cnt == '0);

  intlv_addr_gen #(
    .NCBPS (NCBPS),
    .D     (D),
    .AW    (AW)
  ) u_addr_gen (
    .clk_100 (clk_100),
    .reset   (reset),
    .adv     (w_wr_fire),
    .addr    (w_wr_addr),
    .last    (w_wr_last)
  );

  // A write targets an EMPTY/FILLING bank and a read a FULL/DRAINING one, so
  // the two updates below never touch the same bank in one cycle.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_rd_cnt   <= '0;
    end else begin
      if (w_wr_fire) begin
        r_bank[r_wr_bank][w_wr_addr] <= in_data;
        r_state[r_wr_bank]           <= w_wr_last ? FULL : FILLING;
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
      if (w_rd_fire) begin
        r_state[r_rd_bank] <= w_rd_last ? EMPTY : DRAINING;
        if (w_rd_last) begin
          r_rd_bank <= ~r_rd_bank;
          r_rd_cnt  <= '0;
        end else begin
          r_rd_cnt  <= r_rd_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_interleaver_pingpong.sv
`default_nettype none
// ============================================================================
// Module  : tb_interleaver_pingpong
// Purpose : Self-checking bench for interleaver_pingpong. Expected output
//           bits are queued when a block's last bit is accepted and popped
//           as the DUT delivers output.
// Revision: 1.0 - initial release
// ============================================================================
module tb_interleaver_pingpong;
  import interleaver_pingpong_pkg::*;

  logic clk_100 = 1'b0;
  logic reset;
  logic in_data;
  logic in_valid;
  logic in_ready;
  logic out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic blk_start;

  always #5 clk_100 = ~clk_100;

  interleaver_pingpong dut (
    .clk_100   (clk_100),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .blk_start (blk_start)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  logic         sb[$];
  int           rdy_mode = 0;     // 0: always ready, 1: stalled, 2: random
  int           out_j = 0;
  logic [191:0] coll = '0;
  int           n_xfer = 0;
  int           cyc = 0;
  int           first_cyc = 0;
  int           last_cyc = 0;
  int           n_acc = 0;
  int           n_notready = 0;
  bit           track_ready = 1'b0;

  task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inverse mapping: output position j holds input bit k = 16*(j%12) + j/12.
  function automatic logic [191:0] model(input logic [191:0] blk);
    logic [191:0] r;
    int k;
    r = '0;
    for (int j = 0; j < 192; j++) begin
      k = 16 * (j % 12) + j / 12;
      r[8'(191-j)] = blk[8'(191-k)];
    end
    return r;
  endfunction

  // Output monitor and out_ready driver.
  initial begin
    logic e;
    forever begin
      @(negedge clk_100);
      cyc++;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (reset) out_j = 0;
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_val("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check_val("out_data", out_data, e);
        end
        check_val("blk_start", blk_start, (out_j == 0));
        coll[8'(191-out_j)] = out_data;
        out_j = (out_j == 191) ? 0 : out_j + 1;
        n_xfer++;
        if (n_xfer == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
  end

  task automatic send_block(input logic [191:0] blk, input bit bursty, input int stop_after);
    int wait_cyc;
    int ph;
    logic [191:0] e;
    ph = 0;
    for (int k = 0; k < 192; k++) begin
      if (k == stop_after) begin
        @(negedge clk_100);
        in_valid = 1'b0;
        return;
      end
      wait_cyc = 0;
      forever begin
        @(negedge clk_100);
        in_valid = bursty ? (ph == 0 || ph == 3) : 1'b1;
        ph = (ph + 1) % 4;
        in_data = blk[8'(191-k)];
        if (track_ready && !in_ready) n_notready++;
        if (in_valid && in_ready && !reset) begin
          n_acc++;
          if (k == 191) begin
            e = model(blk);
            for (int j = 0; j < 192; j++) sb.push_back(e[8'(191-j)]);
          end
          break;
        end
        wait_cyc++;
        if (wait_cyc > 1000) begin
          check_val("in_timeout", 1, 0);
          in_valid = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic idle_in();
    @(negedge clk_100);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(negedge clk_100);
      t++;
    end
    check_val("drain_done", (sb.size() == 0), 1);
    repeat (3) @(negedge clk_100);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] blk6;
    logic [191:0] exp6;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 1'b0;
    repeat (3) @(negedge clk_100);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_blk_start", blk_start, 0);
    reset = 1'b0;

    // T1: golden vector, plus one-cycle fill-to-output latency.
    rdy_mode = 0;
    send_block(INTLV_GOLDEN_IN, 1'b0, 192);
    idle_in();
    check_val("t1_latency", out_valid, 1);
    wait_drain();
    check_val("t1_golden", coll, INTLV_GOLDEN_OUT);

    // T2: three blocks back to back, no input stall and no output bubble.
    n_xfer      = 0;
    n_notready  = 0;
    track_ready = 1'b1;
    send_block(INTLV_GOLDEN_IN, 1'b0, 192);
    send_block(~INTLV_GOLDEN_IN, 1'b0, 192);
    send_block(INTLV_GOLDEN_IN, 1'b0, 192);
    idle_in();
    track_ready = 1'b0;
    wait_drain();
    check_val("t2_in_ready", n_notready, 0);
    check_val("t2_xfers", n_xfer, 576);
    check_val("t2_no_bubble", last_cyc - first_cyc, 575);
    check_val("t2_last_blk", coll, INTLV_GOLDEN_OUT);

    // T3: output stalled for 400 cycles while three blocks are offered.
    rdy_mode = 1;
    n_acc    = 0;
    fork
      begin
        send_block(INTLV_GOLDEN_IN, 1'b0, 192);
        send_block(~INTLV_GOLDEN_IN, 1'b0, 192);
        send_block(INTLV_GOLDEN_IN, 1'b0, 192);
        idle_in();
      end
      begin
        repeat (400) @(negedge clk_100);
        check_val("t3_accepted", n_acc, 384);
        check_val("t3_in_ready", in_ready, 0);
        rdy_mode = 0;
      end
    join
    wait_drain();
    check_val("t3_total_acc", n_acc, 576);

    // T4: bursty input with random output readiness.
    rdy_mode = 2;
    send_block(INTLV_GOLDEN_IN, 1'b1, 192);
    idle_in();
    wait_drain();
    rdy_mode = 0;
    check_val("t4_golden", coll, INTLV_GOLDEN_OUT);

    // T5: reset after 100 bits, then one clean golden block.
    send_block(~INTLV_GOLDEN_IN, 1'b0, 100);
    reset = 1'b1;
    @(negedge clk_100);
    reset = 1'b0;
    check_val("t5_in_ready", in_ready, 1);
    check_val("t5_out_valid", out_valid, 0);
    n_xfer = 0;
    send_block(INTLV_GOLDEN_IN, 1'b0, 192);
    idle_in();
    wait_drain();
    repeat (20) @(negedge clk_100);
    check_val("t5_xfers", n_xfer, 192);
    check_val("t5_golden", coll, INTLV_GOLDEN_OUT);
    check_val("t5_idle", out_valid, 0);

    // T6: one-hot at k=17 must land at j=13.
    blk6 = '0;
    blk6[191-17] = 1'b1;
    exp6 = '0;
    exp6[191-13] = 1'b1;
    send_block(blk6, 1'b0, 192);
    idle_in();
    wait_drain();
    check_val("t6_onehot", coll, exp6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
